// File: rtl/multi_chan_tx_buffer.sv
// Per-channel byte FIFOs merged onto one registered TX stream by a round-robin arbiter.
// Each output byte carries its source channel; per-channel sticky overflow flags and an activity LED.
module multi_chan_tx_buffer #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 4,
  parameter  int N_CH     = 2,
  parameter  int LED_HOLD = 1000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst,
  input  logic [N_CH*DATA_W-1:0]   i_in_data,
  input  logic [N_CH-1:0]          i_in_valid,
  output logic [N_CH-1:0]          o_in_ready,
  input  logic [N_CH-1:0]          i_ovf_clr,
  output logic [DATA_W-1:0]        o_tx_data,
  output logic [CH_W-1:0]          o_tx_ch,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [N_CH-1:0]          o_overflow,
  output logic                     o_led
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LED_HOLD + 1);

  // state | meaning: S_EMPTY | output stage holds nothing, S_FULL | tx_data/tx_ch hold a byte
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [DATA_W-1:0] r_mem    [N_CH][DEPTH];
  logic [AW-1:0]     r_wr_ptr [N_CH];
  logic [AW-1:0]     r_rd_ptr [N_CH];
  logic [CW-1:0]     r_count  [N_CH];
  logic [N_CH-1:0]   r_overflow;
  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [CH_W-1:0]   r_tx_ch;
  logic [CH_W-1:0]   r_last;
  logic [LW-1:0]     r_led_cnt;

  logic [N_CH-1:0]   w_in_ready;
  logic [N_CH-1:0]   w_nonempty;
  logic [N_CH-1:0]   w_push;
  logic [N_CH-1:0]   w_pop;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_load;
  logic              w_hs;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign w_in_ready[c] = (r_count[c] != CW'(DEPTH));
    assign w_nonempty[c] = (r_count[c] != '0);
    assign w_push[c]     = i_in_valid[c] & w_in_ready[c];
    assign w_pop[c]      = w_load & (w_grant == CH_W'(c));
  end

  // Search starts one past the last grant so every busy channel gets a turn.
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= N_CH; i++) begin
      w_idx = CH_W'((int'(r_last) + i) % N_CH);
      if (!w_any && w_nonempty[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_hs   = (r_state == S_FULL) & i_tx_ready;
  assign w_load = w_any & ((r_state == S_EMPTY) | i_tx_ready);

  always_ff @(posedge i_clk_sys) begin
    for (int c = 0; c < N_CH; c++) begin
      if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= i_in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + 1'b1;
          2'b01:   r_count[c] <= r_count[c] - 1'b1;
          default: r_count[c] <= r_count[c];
        endcase
        // A drop in the same cycle as a clear must stay visible.
        if (i_in_valid[c] & ~w_in_ready[c]) r_overflow[c] <= 1'b1;
        else if (i_ovf_clr[c])              r_overflow[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_state   <= S_EMPTY;
      r_tx_data <= '0;
      r_tx_ch   <= '0;
      r_last    <= '0;
      r_led_cnt <= '0;
    end else begin
      if (w_hs)                 r_led_cnt <= LW'(LED_HOLD);
      else if (r_led_cnt != '0) r_led_cnt <= r_led_cnt - 1'b1;

      case (r_state)
        S_EMPTY: begin
          if (w_load) r_state <= S_FULL;
        end
        S_FULL: begin
          if (w_hs && !w_load) r_state <= S_EMPTY;
        end
        default: r_state <= S_EMPTY;
      endcase

      if (w_load) begin
        r_tx_data <= r_mem[w_grant][r_rd_ptr[w_grant]];
        r_tx_ch   <= w_grant;
        r_last    <= w_grant;
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_overflow = r_overflow;
  assign o_tx_valid = (r_state == S_FULL);
  assign o_tx_data  = r_tx_data;
  assign o_tx_ch    = r_tx_ch;
  assign o_led      = (r_led_cnt != '0);

endmodule
